match_selector: RTL and testbench

//   Consumes the per-candidate descriptor distances from the distance stage.
//   For each query descriptor, tracks the nearest and second-nearest candidates

---
 rtl/sift_match_pkg.sv | 24 ++
 rtl/best_two_tracker.sv | 76 +++++++
 rtl/match_selector.sv | 121 ++++++++++++
 tb/tb_match_selector.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_match_pkg.sv
// Shared constants and state encoding for the
// nearest-neighbour match selector.
package sift_match_pkg;

  localparam int DIST_W    = 15;
  localparam int IDX_W     = 10;
  localparam int RATIO_NUM = 4;
  localparam int RATIO_DEN = 5;

  localparam logic [DIST_W-1:0] DIST_MAX = '1;

  localparam int RATIO_MAX =
    (RATIO_NUM > RATIO_DEN) ? RATIO_NUM : RATIO_DEN;
  localparam int PROD_W =
    DIST_W + $clog2(RATIO_MAX) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DECIDE,
    OUT
  } state_e;

endpackage

// File: rtl/best_two_tracker.sv
// Running best / second-best distance tracker
// with candidate counter and sticky overflow.
module best_two_tracker
  import sift_match_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              upd,
  input  logic [DIST_W-1:0] d,
  output logic [DIST_W-1:0] best,
  output logic [DIST_W-1:0] second,
  output logic [IDX_W-1:0]  best_idx,
  output logic              ovf
);

  logic [DIST_W-1:0] best_q, best_d;
  logic [DIST_W-1:0] second_q, second_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    best_d   = best_q;
    second_d = second_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    full_d   = full_q;
    ovf_d    = ovf_q;
    if (init) begin
      best_d   = DIST_MAX;
      second_d = DIST_MAX;
      idx_d    = '0;
      cnt_d    = '0;
      full_d   = 1'b0;
      ovf_d    = 1'b0;
    end else if (upd) begin
      if (d < best_q) begin
        second_d = best_q;
        best_d   = d;
        idx_d    = cnt_q;
      end else if (d < second_q) begin
        second_d = d;
      end
      cnt_d = cnt_q + 1'b1;
      // full: all 2**IDX_W indices used; one more beat overflows
      if (cnt_q == '1) full_d = 1'b1;
      if (full_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q   <= DIST_MAX;
      second_q <= DIST_MAX;
      idx_q    <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      best_q   <= best_d;
      second_q <= second_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign best     = best_q;
  assign second   = second_q;
  assign best_idx = idx_q;
  assign ovf      = ovf_q;

endmodule

// File: rtl/match_selector.sv
// Per-query nearest / second-nearest selection
// with ratio test and registered match record.
module match_selector
  import sift_match_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dist_valid,
  output logic              dist_ready,
  input  logic [DIST_W-1:0] dist_data,
  input  logic              dist_last,
  output logic              match_valid,
  input  logic              match_ready,
  output logic [IDX_W-1:0]  match_idx,
  output logic [DIST_W-1:0] match_dist,
  output logic [DIST_W-1:0] match_dist2,
  output logic              match_ok,
  output logic              match_ovf
);

  state_e state_q, state_d;

  logic              valid_q, valid_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic [DIST_W-1:0] dist2_q, dist2_d;
  logic              ok_q, ok_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              init;
  logic [DIST_W-1:0] t_best;
  logic [DIST_W-1:0] t_second;
  logic [IDX_W-1:0]  t_idx;
  logic              t_ovf;
  logic [PROD_W-1:0] lhs;
  logic [PROD_W-1:0] rhs;

  assign dist_ready = (state_q == IDLE) ||
                      (state_q == SCAN);
  assign accept     = dist_valid && dist_ready;
  assign init       = (state_q == OUT) && match_ready;

  best_two_tracker u_trk (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .upd      (accept),
    .d        (dist_data),
    .best     (t_best),
    .second   (t_second),
    .best_idx (t_idx),
    .ovf      (t_ovf)
  );

  // widened so best*DEN and second*NUM never truncate
  assign lhs = PROD_W'(t_best) * PROD_W'(RATIO_DEN);
  assign rhs = PROD_W'(t_second) * PROD_W'(RATIO_NUM);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    dist_d  = dist_q;
    dist2_d = dist2_q;
    ok_d    = ok_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = dist_last ? DECIDE : SCAN;
      end
      SCAN: begin
        if (accept && dist_last) state_d = DECIDE;
      end
      DECIDE: begin
        valid_d = 1'b1;
        idx_d   = t_idx;
        dist_d  = t_best;
        dist2_d = t_second;
        ok_d    = lhs < rhs;
        ovf_d   = t_ovf;
        state_d = OUT;
      end
      OUT: begin
        if (match_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= '0;
      dist_q  <= '0;
      dist2_q <= '0;
      ok_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      dist_q  <= dist_d;
      dist2_q <= dist2_d;
      ok_q    <= ok_d;
      ovf_q   <= ovf_d;
    end
  end

  assign match_valid = valid_q;
  assign match_idx   = idx_q;
  assign match_dist  = dist_q;
  assign match_dist2 = dist2_q;
  assign match_ok    = ok_q;
  assign match_ovf   = ovf_q;

endmodule

// File: tb/tb_match_selector.sv
// Directed self-checking bench for match_selector.
module tb_match_selector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dist_valid = 1'b0;
  logic        dist_ready;
  logic [14:0] dist_data = '0;
  logic        dist_last = 1'b0;
  logic        match_valid;
  logic        match_ready = 1'b0;
  logic [9:0]  match_idx;
  logic [14:0] match_dist;
  logic [14:0] match_dist2;
  logic        match_ok;
  logic        match_ovf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  match_selector dut (
    .clk         (clk),
    .rst         (rst),
    .dist_valid  (dist_valid),
    .dist_ready  (dist_ready),
    .dist_data   (dist_data),
    .dist_last   (dist_last),
    .match_valid (match_valid),
    .match_ready (match_ready),
    .match_idx   (match_idx),
    .match_dist  (match_dist),
    .match_dist2 (match_dist2),
    .match_ok    (match_ok),
    .match_ovf   (match_ovf)
  );

  task automatic beat(input logic [14:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    dist_valid = 1'b1;
    dist_data  = d;
    dist_last  = last;
    while (!dist_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tests++;
      fails++;
      $display("FAIL beat_wait: dist_ready=%0b required 1", dist_ready);
    end
    @(posedge clk);
  endtask

  task automatic end_q();
    @(negedge clk);
    dist_valid = 1'b0;
    dist_last  = 1'b0;
  endtask

  task automatic wait_rec(input string nm);
    int n = 0;
    while (!match_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (match_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_valid: match_valid=%0b required 1", nm, match_valid);
    end
  endtask

  task automatic handshake();
    match_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    match_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({dist_ready, match_valid, match_idx, match_dist, match_dist2,
         match_ok, match_ovf} !== {1'b1, 1'b0, 10'd0, 15'd0, 15'd0,
         1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset: rdy=%0b v=%0b idx=%0d d=%0d d2=%0d ok=%0b ovf=%0b required 1 0 0 0 0 0 0",
               dist_ready, match_valid, match_idx, match_dist, match_dist2,
               match_ok, match_ovf);
    end
  endtask

  task automatic test_basic();
    beat(15'd300, 1'b0);
    beat(15'd120, 1'b0);
    beat(15'd500, 1'b0);
    beat(15'd200, 1'b1);
    end_q();
    wait_rec("basic");
    tests++;
    if ({match_idx, match_dist, match_dist2, match_ok, match_ovf} !==
        {10'd1, 15'd120, 15'd200, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL basic: idx=%0d d=%0d d2=%0d ok=%0b ovf=%0b required 1 120 200 1 0",
               match_idx, match_dist, match_dist2, match_ok, match_ovf);
    end
    handshake();
  endtask

  task automatic test_exact_ratio();
    beat(15'd400, 1'b0);
    beat(15'd500, 1'b1);
    end_q();
    wait_rec("exact");
    tests++;
    if ({match_idx, match_dist, match_dist2, match_ok} !==
        {10'd0, 15'd400, 15'd500, 1'b0}) begin
      fails++;
      $display("FAIL exact_ratio: idx=%0d d=%0d d2=%0d ok=%0b required 0 400 500 0",
               match_idx, match_dist, match_dist2, match_ok);
    end
    handshake();
  endtask

  task automatic test_single_latency();
    beat(15'd1000, 1'b1);
    end_q();
    tests++;
    if ({match_valid, dist_ready} !== 2'b00) begin
      fails++;
      $display("FAIL lat_n1: v=%0b rdy=%0b required 0 0", match_valid, dist_ready);
    end
    @(negedge clk);
    tests++;
    if (match_valid !== 1'b1) begin
      fails++;
      $display("FAIL lat_n2: match_valid=%0b required 1", match_valid);
    end
    tests++;
    if ({match_idx, match_dist, match_dist2, match_ok} !==
        {10'd0, 15'd1000, 15'd32767, 1'b1}) begin
      fails++;
      $display("FAIL single: idx=%0d d=%0d d2=%0d ok=%0b required 0 1000 32767 1",
               match_idx, match_dist, match_dist2, match_ok);
    end
    handshake();
  endtask

  task automatic test_tie();
    beat(15'd150, 1'b0);
    beat(15'd150, 1'b0);
    beat(15'd900, 1'b1);
    end_q();
    wait_rec("tie");
    tests++;
    if ({match_idx, match_dist, match_dist2, match_ok} !==
        {10'd0, 15'd150, 15'd150, 1'b0}) begin
      fails++;
      $display("FAIL tie: idx=%0d d=%0d d2=%0d ok=%0b required 0 150 150 0",
               match_idx, match_dist, match_dist2, match_ok);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    beat(15'd50, 1'b0);
    beat(15'd80, 1'b1);
    end_q();
    wait_rec("bp");
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({match_valid, dist_ready, match_idx, match_dist, match_dist2,
           match_ok} !== {1'b1, 1'b0, 10'd0, 15'd50, 15'd80, 1'b1}) begin
        fails++;
        $display("FAIL hold_%0d: v=%0b rdy=%0b idx=%0d d=%0d d2=%0d ok=%0b required 1 0 0 50 80 1",
                 i, match_valid, dist_ready, match_idx, match_dist,
                 match_dist2, match_ok);
      end
      @(negedge clk);
    end
    handshake();
    tests++;
    if ({match_valid, dist_ready} !== 2'b01) begin
      fails++;
      $display("FAIL after_hs: v=%0b rdy=%0b required 0 1", match_valid, dist_ready);
    end
    dist_valid = 1'b1;
    dist_data  = 15'd700;
    dist_last  = 1'b1;
    @(posedge clk);
    end_q();
    @(negedge clk);
    tests++;
    if ({match_valid, match_dist, match_dist2} !==
        {1'b1, 15'd700, 15'd32767}) begin
      fails++;
      $display("FAIL b2b: v=%0b d=%0d d2=%0d required 1 700 32767",
               match_valid, match_dist, match_dist2);
    end
    handshake();
  endtask

  task automatic test_mid_reset();
    beat(15'd5, 1'b0);
    beat(15'd7, 1'b0);
    @(negedge clk);
    dist_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({match_valid, dist_ready} !== 2'b01) begin
        fails++;
        $display("FAIL mid_rst_%0d: v=%0b rdy=%0b required 0 1",
                 i, match_valid, dist_ready);
      end
      @(negedge clk);
    end
    beat(15'd10, 1'b0);
    beat(15'd90, 1'b1);
    end_q();
    wait_rec("mid_rst");
    tests++;
    if ({match_idx, match_dist, match_dist2, match_ok, match_ovf} !==
        {10'd0, 15'd10, 15'd90, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL mid_rst_rec: idx=%0d d=%0d d2=%0d ok=%0b ovf=%0b required 0 10 90 1 0",
               match_idx, match_dist, match_dist2, match_ok, match_ovf);
    end
    handshake();
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= 1024; i++)
      beat((i == 5) ? 15'd100 : 15'd1000, i == 1024);
    end_q();
    wait_rec("ovf");
    tests++;
    if ({match_idx, match_dist, match_dist2, match_ok, match_ovf} !==
        {10'd5, 15'd100, 15'd1000, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL ovf_1025: idx=%0d d=%0d d2=%0d ok=%0b ovf=%0b required 5 100 1000 1 1",
               match_idx, match_dist, match_dist2, match_ok, match_ovf);
    end
    handshake();
    for (int i = 0; i < 1024; i++)
      beat((i == 1023) ? 15'd50 : 15'd1000, i == 1023);
    end_q();
    wait_rec("full");
    tests++;
    if ({match_idx, match_dist, match_dist2, match_ok, match_ovf} !==
        {10'd1023, 15'd50, 15'd1000, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL full_1024: idx=%0d d=%0d d2=%0d ok=%0b ovf=%0b required 1023 50 1000 1 0",
               match_idx, match_dist, match_dist2, match_ok, match_ovf);
    end
    handshake();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_basic();
    test_exact_ratio();
    test_single_latency();
    test_tie();
    test_backpressure();
    test_mid_reset();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
